mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the core's simple memory bus (addr/wdata/wmask/rdata/wen/ren/done).
- Master 0 is the CPU data/instruction port. Master 1 is a secondary requester (debug loader or DMA).
- Grants are round-robin and non-preemptive. A grant is held until the slave returns done, the watchdog times out, or the master withdraws.
- Sits between the requesters and the memory/peripheral interconnect.

---
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the simple memory bus.
// Grants are non-preemptive and end on slave done, watchdog expiry or master withdrawal.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic [1:0]  grant
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        m0_req, m1_req;
  logic        own0, own1, owned;
  logic        cur_req, cur_wen, cur_ren;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wmask;
  logic        xfer_done, xfer_tmo, route;

  assign m0_req = m0_wen | m0_ren;
  assign m1_req = m1_wen | m1_ren;

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign owned = own0 | own1;

  always_comb begin
    cur_req   = 1'b0;
    cur_wen   = 1'b0;
    cur_ren   = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    cur_wmask = '0;
    if (own0) begin
      cur_req   = m0_req;
      cur_wen   = m0_wen;
      cur_ren   = m0_ren;
      cur_addr  = m0_addr;
      cur_wdata = m0_wdata;
      cur_wmask = m0_wmask;
    end else if (own1) begin
      cur_req   = m1_req;
      cur_wen   = m1_wen;
      cur_ren   = m1_ren;
      cur_addr  = m1_addr;
      cur_wdata = m1_wdata;
      cur_wmask = m1_wmask;
    end
  end

  // Withdrawal takes priority; slave done wins over a coincident watchdog expiry.
  assign xfer_done = owned & cur_req & s_done;
  assign xfer_tmo  = owned & cur_req & ~s_done & TMO_EN & (cnt_q == TMO_LAST);
  assign route     = owned & cur_req & ~xfer_tmo;

  assign s_addr  = route ? cur_addr  : '0;
  assign s_wdata = route ? cur_wdata : '0;
  assign s_wmask = route ? cur_wmask : '0;
  assign s_wen   = route & cur_wen;
  assign s_ren   = route & cur_ren & ~cur_wen;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (m0_req) begin
          state_d = ST_OWN0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!cur_req) begin
          state_d = ST_IDLE;
        end else if (xfer_done || xfer_tmo) begin
          state_d = ST_IDLE;
          last_d  = own1;
        end else begin
          cnt_d = TMO_EN ? cnt_q + CW'(1) : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = state_q;

  assign m0_done  = own0 & (xfer_done | xfer_tmo);
  assign m0_err   = own0 & xfer_tmo;
  assign m0_rdata = (own0 & xfer_done) ? s_rdata :
                    (own0 & xfer_tmo)  ? ERR_RDATA : '0;

  assign m1_done  = own1 & (xfer_done | xfer_tmo);
  assign m1_err   = own1 & xfer_tmo;
  assign m1_rdata = (own1 & xfer_done) ? s_rdata :
                    (own1 & xfer_tmo)  ? ERR_RDATA : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected done responses are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m0_wen, m0_ren, m0_done, m0_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        m1_wen, m1_ren, m1_done, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_wen, s_ren, s_done;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(m0_rdata),
    .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(m1_rdata),
    .m1_done(m1_done), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_wen(s_wen), .s_ren(s_ren), .s_rdata(s_rdata), .s_done(s_done),
    .grant(grant)
  );

  int n_tests = 0;
  int n_fail  = 0;
  // Entry layout: {master, err, rdata}
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic m, input logic err, input logic [31:0] rd);
    exp_q.push_back({m, err, rd});
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_wen = 1'b0; m0_ren = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_wen = 1'b0; m1_ren = 1'b0;
    s_rdata = '0; s_done = 1'b0;
  endtask

  task automatic check_done(input logic m, input logic err, input logic [31:0] rd);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_done: master %0d got done, expected none at %0t", m, $time);
    end else begin
      e = exp_q.pop_front();
      chk("done_master", {31'd0, m}, {31'd0, e[33]});
      chk("done_err", {31'd0, err}, {31'd0, e[32]});
      chk("done_rdata", rd, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (m0_done) check_done(1'b0, m0_err, m0_rdata);
      else begin
        chk("m0_idle_rdata", m0_rdata, 32'd0);
        chk("m0_idle_err", {31'd0, m0_err}, 32'd0);
      end
      if (m1_done) check_done(1'b1, m1_err, m1_rdata);
      else begin
        chk("m1_idle_rdata", m1_rdata, 32'd0);
        chk("m1_idle_err", {31'd0, m1_err}, 32'd0);
      end
    end
  end

  initial begin
    logic [1:0] exp_g [7];
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    clear_inputs();

    // Reset state
    #12;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s_ren", {31'd0, s_ren}, 32'd0);
    chk("rst_m0_done", {31'd0, m0_done}, 32'd0);
    tick();
    rst = 1'b1;

    // Single read
    m0_ren = 1'b1; m0_addr = 32'h100;
    tick(); settle();
    chk("rd_s_ren", {31'd0, s_ren}, 32'd1);
    chk("rd_grant", {30'd0, grant}, 32'd1);
    chk("rd_s_addr", s_addr, 32'h100);
    s_done = 1'b1; s_rdata = 32'h1234_5678;
    push(1'b0, 1'b0, 32'h1234_5678);
    settle();
    chk("rd_m0_done", {31'd0, m0_done}, 32'd1);
    tick();
    m0_ren = 1'b0; s_done = 1'b0;
    settle();
    chk("rd_grant_idle", {30'd0, grant}, 32'd0);
    chk("rd_s_ren_idle", {31'd0, s_ren}, 32'd0);

    // Contention round-robin from a fresh reset
    rst = 1'b0; #2; rst = 1'b1;
    m0_ren = 1'b1; m0_addr = 32'hA0;
    m1_ren = 1'b1; m1_addr = 32'hB0;
    s_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      s_rdata = 32'h1000 + i;
      settle();
      chk("rr_grant", {30'd0, grant}, {30'd0, exp_g[i]});
      if (exp_g[i] == 2'b01) begin
        push(1'b0, 1'b0, 32'h1000 + i);
        chk("rr_s_addr0", s_addr, 32'hA0);
      end else if (exp_g[i] == 2'b10) begin
        push(1'b1, 1'b0, 32'h1000 + i);
        chk("rr_s_addr1", s_addr, 32'hB0);
      end else begin
        chk("rr_s_ren_idle", {31'd0, s_ren}, 32'd0);
      end
    end
    tick();
    clear_inputs();
    settle();
    chk("rr_end_grant", {30'd0, grant}, 32'd0);

    // Write with both strobes high
    m1_wen = 1'b1; m1_ren = 1'b1; m1_wmask = 4'b0100;
    m1_wdata = 32'hAABB_CCDD; m1_addr = 32'h200;
    tick(); settle();
    chk("wr_grant", {30'd0, grant}, 32'd2);
    chk("wr_s_wen", {31'd0, s_wen}, 32'd1);
    chk("wr_s_ren", {31'd0, s_ren}, 32'd0);
    chk("wr_s_wmask", {28'd0, s_wmask}, 32'h4);
    chk("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
    s_done = 1'b1; s_rdata = 32'h55;
    push(1'b1, 1'b0, 32'h55);
    tick();
    clear_inputs();

    // Watchdog timeout after 4 OWN cycles
    m0_ren = 1'b1; m0_addr = 32'h300;
    for (int k = 1; k <= 4; k++) begin
      tick(); settle();
      chk("to_grant", {30'd0, grant}, 32'd1);
      if (k < 4) begin
        chk("to_s_ren", {31'd0, s_ren}, 32'd1);
        chk("to_no_done", {31'd0, m0_done}, 32'd0);
      end else begin
        push(1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("to_s_ren_forced", {31'd0, s_ren}, 32'd0);
      end
    end
    tick();
    m0_ren = 1'b0;
    settle();
    chk("to_grant_idle", {30'd0, grant}, 32'd0);

    // Withdrawal by master 1 while master 0 waits
    m1_ren = 1'b1; m1_addr = 32'h400;
    tick(); settle();
    chk("wd_grant1", {30'd0, grant}, 32'd2);
    m0_ren = 1'b1; m0_addr = 32'h500;
    tick(); settle();
    chk("wd_grant1_hold", {30'd0, grant}, 32'd2);
    m1_ren = 1'b0;
    settle();
    chk("wd_s_ren_drop", {31'd0, s_ren}, 32'd0);
    chk("wd_no_done", {31'd0, m1_done}, 32'd0);
    tick(); settle();
    chk("wd_idle", {30'd0, grant}, 32'd0);
    tick(); settle();
    chk("wd_m0_grant", {30'd0, grant}, 32'd1);
    chk("wd_m0_addr", s_addr, 32'h500);
    s_done = 1'b1; s_rdata = 32'h77;
    push(1'b0, 1'b0, 32'h77);
    tick();
    clear_inputs();

    // Async reset mid-transfer, then contention favours master 0
    m0_ren = 1'b1; m0_addr = 32'h600;
    tick(); settle();
    chk("ar_s_ren", {31'd0, s_ren}, 32'd1);
    chk("ar_grant", {30'd0, grant}, 32'd1);
    #2;
    rst = 1'b0; s_done = 1'b1;
    #1;
    chk("ar_s_ren_rst", {31'd0, s_ren}, 32'd0);
    chk("ar_grant_rst", {30'd0, grant}, 32'd0);
    chk("ar_done_rst", {31'd0, m0_done}, 32'd0);
    chk("ar_s_addr_rst", s_addr, 32'd0);
    tick();
    rst = 1'b1; s_done = 1'b0;
    m1_ren = 1'b1; m1_addr = 32'h700;
    tick(); settle();
    chk("ar_first_grant", {30'd0, grant}, 32'd1);
    s_done = 1'b1; s_rdata = 32'h99;
    push(1'b0, 1'b0, 32'h99);
    tick();
    clear_inputs();
    tick();
    tick();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
